// File: rtl/tmvp_pkg.sv
// Shared widths, opcode encodings and scoreboard entry layout for the fetch/issue front end.
package tmvp_pkg;

    localparam int ADDR_W = 12;
    localparam int REG_AW = 5;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OPC_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD   = 4'h1;
    localparam logic [OPC_W-1:0] OPC_SUB   = 4'h2;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_STORE = 4'h4;
    localparam logic [OPC_W-1:0] OPC_MAC   = 4'h5;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] idx;
    } sb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting lane at or above ptr, wrapping, wins.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fetch_issue_scheduler.sv
// Round-robin lane issue onto the memory_fetch port with a store scoreboard that
// stalls register reads until an in-flight writeback has landed.
module fetch_issue_scheduler #(
    parameter int  NUM_LANES  = 4,
    parameter int  ADDR_W     = tmvp_pkg::ADDR_W,
    parameter int  REG_AW     = tmvp_pkg::REG_AW,
    parameter int  OPC_W      = tmvp_pkg::OPC_W,
    parameter int  WB_LATENCY = 3,
    parameter int  CNT_W      = 16,
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0]        req_valid,
    output logic [NUM_LANES-1:0]        req_ready,
    input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
    input  logic [NUM_LANES-1:0]        req_is_imm,
    input  logic [NUM_LANES-1:0]        req_is_load,
    input  logic [NUM_LANES-1:0]        req_is_store,
    input  logic [NUM_LANES*OPC_W-1:0]  req_opcode,
    input  logic                        pipe_hold,
    output logic                        mf_issue,
    output logic [LANE_W-1:0]           mf_lane,
    output logic [ADDR_W-1:0]           mf_addr,
    output logic                        mf_is_imm,
    output logic                        mf_is_load,
    output logic                        mf_is_store,
    output logic [OPC_W-1:0]            mf_opcode,
    output logic                        err_addr,
    output logic [CNT_W-1:0]            issue_cnt,
    output logic [CNT_W-1:0]            hazard_cnt
);

    // The accept cycle itself is the first of the WB_LATENCY cycles, so only
    // WB_LATENCY-1 registered slots are ever visible to later readers.
    localparam bit SB_ON    = (WB_LATENCY > 1);
    localparam int SB_DEPTH = SB_ON ? WB_LATENCY - 1 : 1;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] idx;
    } sb_slot_t;

    logic [ADDR_W-1:0]    lane_addr [NUM_LANES];
    logic [OPC_W-1:0]     lane_opc  [NUM_LANES];
    logic [NUM_LANES-1:0] reads_reg;
    logic [NUM_LANES-1:0] hazard;
    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] grant;
    logic [LANE_W-1:0]    grant_idx;
    logic                 grant_any;

    sb_slot_t             sb_q [SB_DEPTH];
    sb_slot_t             sb_d [SB_DEPTH];
    logic [LANE_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic                 mf_issue_q,   mf_issue_d;
    logic [LANE_W-1:0]    mf_lane_q,    mf_lane_d;
    logic [ADDR_W-1:0]    mf_addr_q,    mf_addr_d;
    logic                 mf_is_imm_q,  mf_is_imm_d;
    logic                 mf_is_load_q, mf_is_load_d;
    logic                 mf_is_store_q, mf_is_store_d;
    logic [OPC_W-1:0]     mf_opcode_q,  mf_opcode_d;
    logic                 err_addr_q,   err_addr_d;
    logic [CNT_W-1:0]     issue_cnt_q,  issue_cnt_d;
    logic [CNT_W-1:0]     hazard_cnt_q, hazard_cnt_d;

    logic [ADDR_W-1:0]    sel_addr;
    logic [OPC_W-1:0]     sel_opc;
    logic                 sel_imm;
    logic                 sel_load;
    logic                 sel_store;
    logic                 sel_reads;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic hit;
            assign lane_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign lane_opc[gi]  = req_opcode[gi*OPC_W +: OPC_W];
            // Address 0 is the data_in bypass and never touches the register file.
            assign reads_reg[gi] = !req_is_imm[gi] && (lane_addr[gi] != '0);
            always_comb begin
                hit = 1'b0;
                for (int s = 0; s < SB_DEPTH; s++) begin
                    if (sb_q[s].v && (sb_q[s].idx == lane_addr[gi][REG_AW-1:0])) hit = 1'b1;
                end
            end
            assign hazard[gi]   = reads_reg[gi] && hit;
            assign eligible[gi] = req_valid[gi] && !hazard[gi] && !pipe_hold && !rst;
        end
    endgenerate

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_addr  = lane_addr[grant_idx];
    assign sel_opc   = lane_opc[grant_idx];
    assign sel_imm   = req_is_imm[grant_idx];
    assign sel_load  = req_is_load[grant_idx];
    assign sel_store = req_is_store[grant_idx];
    assign sel_reads = reads_reg[grant_idx];

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        mf_issue_d    = grant_any;
        mf_lane_d     = '0;
        mf_addr_d     = '0;
        mf_is_imm_d   = 1'b0;
        mf_is_load_d  = 1'b0;
        mf_is_store_d = 1'b0;
        mf_opcode_d   = '0;
        err_addr_d    = err_addr_q;
        issue_cnt_d   = issue_cnt_q;
        hazard_cnt_d  = hazard_cnt_q;

        if (grant_any) begin
            rr_ptr_d      = (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + LANE_W'(1);
            mf_lane_d     = grant_idx;
            mf_addr_d     = sel_addr;
            mf_is_imm_d   = sel_imm;
            mf_is_load_d  = sel_load;
            mf_is_store_d = sel_store;
            mf_opcode_d   = sel_opc;
            if (sel_reads && ((sel_addr >> REG_AW) != '0)) err_addr_d = 1'b1;
            if (issue_cnt_q != {CNT_W{1'b1}}) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (!pipe_hold && (|req_valid) && !grant_any && (hazard_cnt_q != {CNT_W{1'b1}})) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end

        sb_d[0].v   = grant_any && sel_store && SB_ON;
        sb_d[0].idx = sel_addr[REG_AW-1:0];
        for (int s = 1; s < SB_DEPTH; s++) sb_d[s] = sb_q[s-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            mf_issue_q    <= 1'b0;
            mf_lane_q     <= '0;
            mf_addr_q     <= '0;
            mf_is_imm_q   <= 1'b0;
            mf_is_load_q  <= 1'b0;
            mf_is_store_q <= 1'b0;
            mf_opcode_q   <= '0;
            err_addr_q    <= 1'b0;
            issue_cnt_q   <= '0;
            hazard_cnt_q  <= '0;
            for (int s = 0; s < SB_DEPTH; s++) sb_q[s] <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            mf_issue_q    <= mf_issue_d;
            mf_lane_q     <= mf_lane_d;
            mf_addr_q     <= mf_addr_d;
            mf_is_imm_q   <= mf_is_imm_d;
            mf_is_load_q  <= mf_is_load_d;
            mf_is_store_q <= mf_is_store_d;
            mf_opcode_q   <= mf_opcode_d;
            err_addr_q    <= err_addr_d;
            issue_cnt_q   <= issue_cnt_d;
            hazard_cnt_q  <= hazard_cnt_d;
            for (int s = 0; s < SB_DEPTH; s++) sb_q[s] <= sb_d[s];
        end
    end

    assign req_ready   = grant;
    assign mf_issue    = mf_issue_q;
    assign mf_lane     = mf_lane_q;
    assign mf_addr     = mf_addr_q;
    assign mf_is_imm   = mf_is_imm_q;
    assign mf_is_load  = mf_is_load_q;
    assign mf_is_store = mf_is_store_q;
    assign mf_opcode   = mf_opcode_q;
    assign err_addr    = err_addr_q;
    assign issue_cnt   = issue_cnt_q;
    assign hazard_cnt  = hazard_cnt_q;

endmodule
